pipe_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage for the pipelined MIPS core. It replaces the single-register PC/IF_ID pair with a PC generator feeding a DEPTH-entry instruction queue. Fetch keeps running while decode is stalled, up to the queue depth. Branch or jump redirects flush all queued instructions and restart fetch at the target; the decode stage sees a NOP bubble whenever no instruction is valid.

---
 rtl/pipe_fetch_queue_if.sv | 45 ++++
 rtl/pipe_fetch_queue.sv | 119 +++++++++++
 tb/tb_pipe_fetch_queue.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_fetch_queue_if.sv
// Fetch-stage bus: instruction-memory lookup, redirect/stall control from
// the rest of the pipeline, and the head-of-queue view handed to decode.
interface pipe_fetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int IM_AW  = 5,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [IM_AW-1:0]  im_addr;
    logic [31:0]       im_data;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall;
    logic              out_valid;
    logic [31:0]       out_ir;
    logic [ADDR_W-1:0] out_pc_4;
    logic [CW-1:0]     count;

    // The fetch queue drives the IM address and the decode-facing head.
    modport master (
        output im_addr,
        output out_valid,
        output out_ir,
        output out_pc_4,
        output count,
        input  im_data,
        input  redirect,
        input  redirect_pc,
        input  stall
    );

    // The surrounding core: IM, branch/jump resolution and decode.
    modport slave (
        input  im_addr,
        input  out_valid,
        input  out_ir,
        input  out_pc_4,
        input  count,
        output im_data,
        output redirect,
        output redirect_pc,
        output stall
    );
endinterface

// File: rtl/pipe_fetch_queue.sv
// Instruction-fetch stage: a PC generator that keeps fetching into a
// DEPTH-entry circular queue while decode stalls. A redirect flushes the
// queue and restarts fetch at the target; decode sees a NOP when empty.
module pipe_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                IM_AW    = 5,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_fetch_queue_if.master    bus
);
    localparam int                PW      = $clog2(DEPTH);
    localparam int                CW      = PW + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [PW-1:0]     PTR_ONE = PW'(1);

    // Architectural state
    logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
    logic [PW-1:0]     wr_ptr_reg,   wr_ptr_next;
    logic [PW-1:0]     rd_ptr_reg,   rd_ptr_next;
    logic [CW-1:0]     count_reg,    count_next;

    // Queue storage (deliberately not reset; pointers/count define validity)
    logic [31:0]       ir_mem  [DEPTH];
    logic [ADDR_W-1:0] pc4_mem [DEPTH];

    logic              head_valid;
    logic              pop_req;
    logic              pop;
    logic              push;
    logic [ADDR_W-1:0] pc_plus_4;
    logic [DEPTH-1:0]  entry_we;

    assign head_valid = (count_reg != '0);
    assign pc_plus_4  = fetch_pc_reg + PC_STEP;

    // Decode consumes the head whenever it is valid and not holding.
    assign pop_req = head_valid & ~bus.stall;

    // A redirect discards the whole queue, so a same-cycle pop is not recorded.
    assign pop = pop_req & ~bus.redirect;

    // Fetch proceeds when there is room, or when the head leaves this cycle
    // (full + pop keeps one instruction per cycle flowing).
    assign push = ~bus.redirect & ((count_reg < DEPTH_C) | pop_req);

    // One write-enable per queue slot, selected by the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry_we
            assign entry_we[gi] = push & (wr_ptr_reg == PW'(gi));
        end
    endgenerate

    // Next-state for pointers, occupancy and PC; redirect overrides all.
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        if (bus.redirect) begin
            fetch_pc_next = bus.redirect_pc;
            wr_ptr_next   = '0;
            rd_ptr_next   = '0;
            count_next    = '0;
        end else begin
            if (push) begin
                fetch_pc_next = pc_plus_4;
                wr_ptr_next   = wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + PTR_ONE;
            end
            count_next = count_reg + CW'(push) - CW'(pop);
        end
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_reg <= RESET_PC;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            fetch_pc_reg <= fetch_pc_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
        end
    end

    // Capture the fetched instruction and its PC+4 into the slot at wr_ptr.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_we[i]) begin
                ir_mem[i]  <= bus.im_data;
                pc4_mem[i] <= pc_plus_4;
            end
        end
    end

    // Head view is combinational; an empty queue presents a NOP bubble.
    always_comb begin
        bus.out_valid = head_valid;
        bus.out_ir    = 32'h0;
        bus.out_pc_4  = '0;
        if (head_valid) begin
            bus.out_ir   = ir_mem[rd_ptr_reg];
            bus.out_pc_4 = pc4_mem[rd_ptr_reg];
        end
    end

    assign bus.im_addr = fetch_pc_reg[IM_AW+1:2];
    assign bus.count   = count_reg;

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue with a scoreboard of expected queue
// contents, updated as stimulus is applied and compared at every cycle.
module tb_pipe_fetch_queue;
    localparam int ADDR_W = 32;
    localparam int IM_AW  = 5;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] pc4;
    } ent_t;

    logic clk;
    logic rst;
    logic [31:0] im_mem [32];

    int total = 0;
    int bad   = 0;

    ent_t        exp_q[$];
    logic [31:0] m_pc;

    pipe_fetch_queue_if #(.ADDR_W(ADDR_W), .IM_AW(IM_AW), .DEPTH(DEPTH)) bus ();

    pipe_fetch_queue #(
        .ADDR_W  (ADDR_W),
        .IM_AW   (IM_AW),
        .DEPTH   (DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.im_data = im_mem[bus.im_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] im_word(input logic [31:0] pc);
        logic [4:0] idx;
        idx = pc[6:2];
        return 32'h1000_0000 + {27'd0, idx};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Compare the DUT head/occupancy/PC against the scoreboard.
    task automatic check_head();
        logic [31:0] e_ir;
        logic [31:0] e_pc4;
        logic [4:0]  e_ia;
        e_ir  = 32'h0;
        e_pc4 = 32'h0;
        if (exp_q.size() != 0) begin
            e_ir  = exp_q[0].ir;
            e_pc4 = exp_q[0].pc4;
        end
        e_ia = m_pc[6:2];
        chk("count",     32'(bus.count),     32'(exp_q.size()));
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        chk("out_ir",    bus.out_ir,         e_ir);
        chk("out_pc_4",  bus.out_pc_4,       e_pc4);
        chk("im_addr",   32'(bus.im_addr),   32'(e_ia));
    endtask

    // One clock cycle: predict, clock, update scoreboard, compare.
    task automatic step();
        bit   m_pop;
        bit   m_push;
        ent_t e;
        m_pop  = (exp_q.size() != 0) && !bus.stall;
        m_push = !bus.redirect && ((exp_q.size() < DEPTH) || m_pop);
        @(posedge clk);
        if (bus.redirect) begin
            exp_q.delete();
            m_pc = bus.redirect_pc;
            $display("redirect pc=%h", m_pc);
        end else begin
            if (m_pop) begin
                e = exp_q.pop_front();
                $display("pop ir=%h pc4=%h", e.ir, e.pc4);
            end
            if (m_push) begin
                e.ir  = im_word(m_pc);
                e.pc4 = m_pc + 32'd4;
                exp_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
        end
        #1;
        check_head();
    endtask

    // Reset pulse placed between clock edges; effect must be immediate.
    task automatic async_reset();
        #2 rst = 1'b0;
        #1;
        exp_q.delete();
        m_pc = 32'h0;
        chk("rst_valid_now", 32'(bus.out_valid), 32'h0);
        chk("rst_count_now", 32'(bus.count), 32'h0);
        check_head();
        @(negedge clk);
        rst = 1'b1;
        $display("reset released");
    endtask

    initial begin
        for (int k = 0; k < 32; k++) im_mem[k] = 32'h1000_0000 + k;
        rst             = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        exp_q.delete();
        m_pc = 32'h0;

        // Reset state
        #3;
        chk("reset_valid",   32'(bus.out_valid), 32'h0);
        chk("reset_im_addr", 32'(bus.im_addr),   32'h0);
        chk("reset_ir",      bus.out_ir,         32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        chk("first_ir",  bus.out_ir,   32'h1000_0000);
        chk("first_pc4", bus.out_pc_4, 32'h4);
        repeat (3) step();

        // Fill and drain
        async_reset();
        bus.stall = 1'b1;
        repeat (6) step();
        chk("fill_count",   32'(bus.count),   32'd4);
        chk("fill_im_addr", 32'(bus.im_addr), 32'd4);
        bus.stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("drain_ir", bus.out_ir, 32'h1000_0000 + 32'(k));
            step();
        end

        // Redirect during normal fetch with count=2
        async_reset();
        bus.stall = 1'b1;
        repeat (2) step();
        chk("pre_redir_count", 32'(bus.count), 32'd2);
        bus.stall       = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        chk("redir_count",   32'(bus.count),     32'd0);
        chk("redir_valid",   32'(bus.out_valid), 32'd0);
        chk("redir_ir",      bus.out_ir,         32'h0);
        chk("redir_im_addr", 32'(bus.im_addr),   32'd16);
        step();
        chk("redir_tgt_ir",  bus.out_ir,   32'h1000_0010);
        chk("redir_tgt_pc4", bus.out_pc_4, 32'h44);

        // Redirect while stalled and full
        bus.stall = 1'b1;
        repeat (4) step();
        chk("full_count", 32'(bus.count), 32'd4);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h20;
        step();
        bus.redirect = 1'b0;
        chk("flush_count", 32'(bus.count), 32'd0);
        bus.stall = 1'b0;
        step();
        chk("flush_tgt_ir", bus.out_ir, 32'h1000_0008);

        // Full with simultaneous pop
        bus.stall = 1'b1;
        repeat (4) step();
        for (int k = 0; k < 4; k++) begin
            bus.stall = (k % 2 == 0);
            step();
            chk("full_pop_count", 32'(bus.count), 32'd4);
        end

        // PC wrap at the top of the address space
        bus.stall       = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        bus.redirect = 1'b0;
        step();
        chk("wrap_ir",      bus.out_ir,       32'h1000_001F);
        chk("wrap_pc4",     bus.out_pc_4,     32'h0);
        chk("wrap_im_addr", 32'(bus.im_addr), 32'h0);

        // Asynchronous reset mid-operation with count=3
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        step();
        bus.redirect = 1'b0;
        bus.stall    = 1'b1;
        repeat (3) step();
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        async_reset();
        bus.stall = 1'b0;
        step();
        chk("restart_ir",  bus.out_ir,   32'h1000_0000);
        chk("restart_pc4", bus.out_pc_4, 32'h4);
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
